hazard_stall_unit: RTL and testbench

//  Parametrised pipeline hazard/stall controller between decode and post-decode stages.

---
 rtl/hazard_stall_unit_pkg.sv | 28 ++
 rtl/stall_echo_counter.sv | 45 ++++
 rtl/hazard_stall_unit.sv | 161 ++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types for the decode/post-decode hazard and stall controller.
//  - hz_src_e    : bit positions of the individual stall causes
//  - out_state_e : output-transfer handshake states
//  - fwd_hit_t   : per-stage forwarding view for the three-operand (d,s,t) decode
//  - RIDX_W_DEF  : default register index width
package hazard_stall_unit_pkg;

  localparam int RIDX_W_DEF = 5;

  typedef enum logic [1:0] {
    HZ_LOAD   = 2'd0,
    HZ_MULDIV = 2'd1,
    HZ_OUT    = 2'd2
  } hz_src_e;

  typedef enum logic [0:0] {
    OUT_IDLE = 1'b0,
    OUT_WAIT = 1'b1
  } out_state_e;

  // One post-decode stage's forwarding hits, one bit per decode operand.
  typedef struct packed {
    logic d;
    logic s;
    logic t;
  } fwd_hit_t;

endpackage

// File: rtl/stall_echo_counter.sv
// Retriggerable window generator.
//  clk, rstn : clock, async active-low reset
//  trig      : reloads the window counter with LAT
//  window    : high for LAT cycles after the last trig cycle (registered)
module stall_echo_counter #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic trig,
  output logic window
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;
  logic          window_q;

  // Next window count: reload on trigger, otherwise drain to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (trig) begin
      cnt_d = CW'(LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Window counter and its registered non-zero flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      window_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      window_q <= (cnt_d != '0);
    end
  end

  assign window = window_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller between decode and the post-decode stages.
//  dec_src_*    : decode source operands (valid, packed indices, operand j at bits j*RIDX_W)
//  dec_muldiv*  : decode starts a mul/div and its destination
//  pos_*        : post-decode stage destinations (stage 0 youngest) and load flags
//  out_req/ack  : output transfer handshake
//  fwd_hit      : bit i*NSRC+j set when stage i can forward to source j
//  stall_pc     : hold PC/decode this cycle (combinational)
//  stall_phase  : registered stall window, LOAD_LATENCY cycles past the last stall
//  muldiv_busy  : mul/div occupancy counter non-zero
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int LOAD_LATENCY   = 1,
  parameter int POST_DEC_LD    = 3,
  parameter int NSRC           = 3,
  parameter int LOAD_HAZ_DEPTH = 3,
  parameter int MULDIV_LAT     = 4,
  parameter int RIDX_W         = RIDX_W_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NSRC-1:0]               dec_src_vld,
  input  logic [NSRC*RIDX_W-1:0]        dec_src_idx,
  input  logic                          dec_muldiv,
  input  logic [RIDX_W-1:0]             dec_muldiv_dst,
  input  logic [POST_DEC_LD-1:0]        pos_dst_vld,
  input  logic [POST_DEC_LD*RIDX_W-1:0] pos_dst_idx,
  input  logic [POST_DEC_LD-1:0]        pos_is_load,
  input  logic                          out_req,
  input  logic                          out_ack,
  output logic [POST_DEC_LD*NSRC-1:0]   fwd_hit,
  output logic                          stall_pc,
  output logic                          stall_phase,
  output logic                          muldiv_busy
);

  localparam int MDW = $clog2(MULDIV_LAT + 1);

  localparam logic [0:0] ST_IDLE = OUT_IDLE;
  localparam logic [0:0] ST_WAIT = OUT_WAIT;

  logic [POST_DEC_LD-1:0] ld_stage_hit;
  logic [NSRC-1:0]        md_src_hit;
  logic                   load_haz;
  logic                   md_haz;
  logic                   out_haz;
  logic [2:0]             hz_vec;
  logic                   md_load;

  logic [MDW-1:0]         md_cnt_d,    md_cnt_q;
  logic [RIDX_W-1:0]      busy_dst_d,  busy_dst_q;
  logic                   md_busy_q;
  logic [0:0]             state_d,     state_q;

  // Forwarding matrix; register 0 never produces a hit.
  for (genvar i = 0; i < POST_DEC_LD; i++) begin : g_stage
    for (genvar j = 0; j < NSRC; j++) begin : g_src
      assign fwd_hit[i*NSRC+j] = dec_src_vld[j] & pos_dst_vld[i]
                               & (dec_src_idx[j*RIDX_W +: RIDX_W] == pos_dst_idx[i*RIDX_W +: RIDX_W])
                               & (dec_src_idx[j*RIDX_W +: RIDX_W] != '0);
    end
    // Only the youngest LOAD_HAZ_DEPTH stages can still deliver load data too late.
    if (i < LOAD_HAZ_DEPTH) begin : g_ld
      assign ld_stage_hit[i] = pos_is_load[i] & (|fwd_hit[i*NSRC +: NSRC]);
    end else begin : g_no_ld
      assign ld_stage_hit[i] = 1'b0;
    end
  end

  assign load_haz = |ld_stage_hit;

  // Sources that read the register the busy mul/div will write.
  for (genvar j = 0; j < NSRC; j++) begin : g_md_src
    assign md_src_hit[j] = dec_src_vld[j]
                         & (dec_src_idx[j*RIDX_W +: RIDX_W] == busy_dst_q)
                         & (dec_src_idx[j*RIDX_W +: RIDX_W] != '0);
  end

  assign muldiv_busy = md_busy_q;
  // A second mul/div is also held off while the unit is occupied.
  assign md_haz      = md_busy_q & (dec_muldiv | (|md_src_hit));

  // Output handshake FSM; a same-cycle ack in IDLE completes without stalling.
  always_comb begin
    state_d = state_q;
    out_haz = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (out_req && !out_ack) begin
          state_d = ST_WAIT;
          out_haz = 1'b1;
        end else begin
          state_d = ST_IDLE;
          out_haz = 1'b0;
        end
      end
      ST_WAIT: begin
        if (out_ack) begin
          state_d = ST_IDLE;
          out_haz = 1'b0;
        end else begin
          state_d = ST_WAIT;
          out_haz = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_haz = 1'b0;
      end
    endcase
  end

  assign hz_vec[HZ_LOAD]   = load_haz;
  assign hz_vec[HZ_MULDIV] = md_haz;
  assign hz_vec[HZ_OUT]    = out_haz;
  assign stall_pc          = |hz_vec;

  // A mul/div only issues when decode actually advances.
  assign md_load = dec_muldiv & ~stall_pc;

  // Mul/div occupancy counter and captured destination.
  always_comb begin
    md_cnt_d   = md_cnt_q;
    busy_dst_d = busy_dst_q;
    if (md_load) begin
      md_cnt_d   = MDW'(MULDIV_LAT);
      busy_dst_d = dec_muldiv_dst;
    end else if (md_cnt_q != '0) begin
      md_cnt_d   = md_cnt_q - MDW'(1);
      busy_dst_d = busy_dst_q;
    end else begin
      md_cnt_d   = md_cnt_q;
      busy_dst_d = busy_dst_q;
    end
  end

  // State registers for mul/div tracking and the output FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      md_cnt_q   <= '0;
      busy_dst_q <= '0;
      md_busy_q  <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      md_cnt_q   <= md_cnt_d;
      busy_dst_q <= busy_dst_d;
      md_busy_q  <= (md_cnt_d != '0);
      state_q    <= state_d;
    end
  end

  stall_echo_counter #(
    .LAT (LOAD_LATENCY)
  ) u_echo (
    .clk    (clk),
    .rstn   (rstn),
    .trig   (stall_pc),
    .window (stall_phase)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized scoreboard bench for hazard_stall_unit with a cycle-indexed reference model.
module tb_hazard_stall_unit;

  localparam int LL  = 3;
  localparam int LD  = 3;
  localparam int NS  = 3;
  localparam int LHD = 3;
  localparam int MDL = 4;
  localparam int RW  = 5;

  typedef struct packed {
    logic [LD*NS-1:0] hit;
    logic             stall;
    logic             phase;
    logic             busy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [NS-1:0]     dec_src_vld;
  logic [NS*RW-1:0]  dec_src_idx;
  logic              dec_muldiv;
  logic [RW-1:0]     dec_muldiv_dst;
  logic [LD-1:0]     pos_dst_vld;
  logic [LD*RW-1:0]  pos_dst_idx;
  logic [LD-1:0]     pos_is_load;
  logic              out_req;
  logic              out_ack;
  logic [LD*NS-1:0]  fwd_hit;
  logic              stall_pc;
  logic              stall_phase;
  logic              muldiv_busy;

  hazard_stall_unit #(
    .LOAD_LATENCY   (LL),
    .POST_DEC_LD    (LD),
    .NSRC           (NS),
    .LOAD_HAZ_DEPTH (LHD),
    .MULDIV_LAT     (MDL),
    .RIDX_W         (RW)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .dec_src_vld    (dec_src_vld),
    .dec_src_idx    (dec_src_idx),
    .dec_muldiv     (dec_muldiv),
    .dec_muldiv_dst (dec_muldiv_dst),
    .pos_dst_vld    (pos_dst_vld),
    .pos_dst_idx    (pos_dst_idx),
    .pos_is_load    (pos_is_load),
    .out_req        (out_req),
    .out_ack        (out_ack),
    .fwd_hit        (fwd_hit),
    .stall_pc       (stall_pc),
    .stall_phase    (stall_phase),
    .muldiv_busy    (muldiv_busy)
  );

  // Staged stimulus for the next cycle.
  logic              n_rstn;
  logic [NS-1:0]     n_src_vld;
  logic [NS*RW-1:0]  n_src_idx;
  logic              n_muldiv;
  logic [RW-1:0]     n_md_dst;
  logic [LD-1:0]     n_dst_vld;
  logic [LD*RW-1:0]  n_dst_idx;
  logic [LD-1:0]     n_is_load;
  logic              n_req;
  logic              n_ack;

  // Reference model state, expressed in absolute cycle numbers.
  int         cyc         = 0;
  int         md_load_cyc = -1000;
  int         last_stall  = -1000;
  logic [RW-1:0] md_dst   = '0;
  bit         out_wait    = 1'b0;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic exp_t model_eval();
    exp_t e;
    bit   load_h, md_h, out_h, busy;
    logic [RW-1:0] s, d;
    e = '0;
    load_h = 1'b0;
    md_h   = 1'b0;
    busy   = (cyc - md_load_cyc >= 1) && (cyc - md_load_cyc <= MDL);
    for (int i = 0; i < LD; i++) begin
      for (int j = 0; j < NS; j++) begin
        s = dec_src_idx[j*RW +: RW];
        d = pos_dst_idx[i*RW +: RW];
        e.hit[i*NS+j] = dec_src_vld[j] && pos_dst_vld[i] && (s == d) && (s != 0);
        if (e.hit[i*NS+j] && pos_is_load[i] && i < LHD) load_h = 1'b1;
      end
    end
    if (busy && dec_muldiv) md_h = 1'b1;
    for (int j = 0; j < NS; j++) begin
      s = dec_src_idx[j*RW +: RW];
      if (busy && dec_src_vld[j] && s == md_dst && s != 0) md_h = 1'b1;
    end
    out_h   = out_wait ? !out_ack : (out_req && !out_ack);
    e.stall = load_h || md_h || out_h;
    e.phase = (cyc - last_stall >= 1) && (cyc - last_stall <= LL);
    e.busy  = busy;
    return e;
  endfunction

  task automatic model_clear();
    md_load_cyc = -1000;
    last_stall  = -1000;
    out_wait    = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_step();
    exp_t e;
    if (!rstn) begin
      model_clear();
    end else begin
      e = model_eval();
      if (dec_muldiv && !e.stall) begin
        md_load_cyc = cyc;
        md_dst      = dec_muldiv_dst;
      end
      if (e.stall) last_stall = cyc;
      out_wait = out_wait ? !out_ack : (out_req && !out_ack);
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    rstn           = n_rstn;
    dec_src_vld    = n_src_vld;
    dec_src_idx    = n_src_idx;
    dec_muldiv     = n_muldiv;
    dec_muldiv_dst = n_md_dst;
    pos_dst_vld    = n_dst_vld;
    pos_dst_idx    = n_dst_idx;
    pos_is_load    = n_is_load;
    out_req        = n_req;
    out_ack        = n_ack;
    sb_q.push_back(model_eval());
  endtask

  task automatic idle_inputs();
    n_rstn    = 1'b1;
    n_src_vld = '0;
    n_src_idx = '0;
    n_muldiv  = 1'b0;
    n_md_dst  = '0;
    n_dst_vld = '0;
    n_dst_idx = '0;
    n_is_load = '0;
    n_req     = 1'b0;
    n_ack     = 1'b0;
  endtask

  task automatic load_hit_cycle();
    idle_inputs();
    n_src_vld = 3'b001;
    n_src_idx = {5'd0, 5'd0, 5'd7};
    n_dst_vld = 3'b001;
    n_dst_idx = {5'd0, 5'd0, 5'd7};
    n_is_load = 3'b001;
  endtask

  // Monitor: every cycle the DUT presents a response; compare it with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("fwd_hit",     32'(fwd_hit),     32'(e.hit));
      check("stall_pc",    32'(stall_pc),    32'(e.stall));
      check("stall_phase", 32'(stall_phase), 32'(e.phase));
      check("muldiv_busy", 32'(muldiv_busy), 32'(e.busy));
    end
  end

  initial begin
    exp_t e;
    idle_inputs();
    n_rstn         = 1'b0;
    rstn           = 1'b0;
    dec_src_vld    = '0;
    dec_src_idx    = '0;
    dec_muldiv     = 1'b0;
    dec_muldiv_dst = '0;
    pos_dst_vld    = '0;
    pos_dst_idx    = '0;
    pos_is_load    = '0;
    out_req        = 1'b0;
    out_ack        = 1'b0;
    repeat (2) tick();
    idle_inputs();
    tick();

    // Load-use hit on source 0, then quiet cycles to watch the window.
    load_hit_cycle();
    tick();
    idle_inputs();
    repeat (4) tick();

    // Register 0 never hits.
    n_src_vld = 3'b111;
    n_dst_vld = 3'b010;
    n_is_load = 3'b111;
    tick();
    idle_inputs();
    tick();

    // Mul/div to r9, then r9 read for five cycles.
    n_muldiv = 1'b1;
    n_md_dst = 5'd9;
    tick();
    idle_inputs();
    n_src_vld = 3'b001;
    n_src_idx = {5'd0, 5'd0, 5'd9};
    repeat (5) tick();
    idle_inputs();
    repeat (4) tick();

    // Output request acked three cycles later, then a same-cycle ack.
    n_req = 1'b1;
    repeat (3) tick();
    n_ack = 1'b1;
    tick();
    idle_inputs();
    repeat (4) tick();
    n_req = 1'b1;
    n_ack = 1'b1;
    tick();
    idle_inputs();
    repeat (4) tick();

    // Two stall pulses two cycles apart stretch one window.
    load_hit_cycle();
    tick();
    idle_inputs();
    tick();
    load_hit_cycle();
    tick();
    idle_inputs();
    repeat (5) tick();

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      n_rstn    = 1'b1;
      n_src_vld = NS'($urandom);
      for (int j = 0; j < NS; j++) n_src_idx[j*RW +: RW] = RW'($urandom_range(0, 7));
      n_dst_vld = LD'($urandom);
      for (int i = 0; i < LD; i++) n_dst_idx[i*RW +: RW] = RW'($urandom_range(0, 7));
      n_is_load = LD'($urandom);
      n_muldiv  = ($urandom_range(0, 5) == 0);
      n_md_dst  = RW'($urandom_range(0, 7));
      n_req     = ($urandom_range(0, 3) == 0);
      n_ack     = ($urandom_range(0, 1) == 1);
      tick();
    end

    // Mid-operation reset with mul/div busy and the output FSM waiting.
    idle_inputs();
    repeat (2) tick();
    n_muldiv = 1'b1;
    n_md_dst = 5'd12;
    tick();
    idle_inputs();
    n_req = 1'b1;
    tick();
    idle_inputs();
    n_src_vld = 3'b001;
    n_src_idx = {5'd0, 5'd0, 5'd12};
    tick();
    @(negedge clk);
    #2;
    rstn   = 1'b0;
    n_rstn = 1'b0;
    #1;
    model_clear();
    e = model_eval();
    check("rst_busy",     32'(muldiv_busy), 32'(0));
    check("rst_phase",    32'(stall_phase), 32'(0));
    check("rst_stall_pc", 32'(stall_pc),    32'(e.stall));
    tick();
    idle_inputs();
    repeat (3) tick();
    load_hit_cycle();
    tick();
    idle_inputs();
    repeat (4) tick();

    repeat (3) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
